mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage load/store sequencer between the EX/MEM pipeline register and the L1 data cache.
- Converts a pipeline memory op into a single word-aligned cache request with byte strobes and replicated store data.
- Stalls the pipeline until the cache answers.
- Hands the raw read word, byte address and load type to the downstream load extender, which does byte/halfword select and sign/zero extension.

Parameters:
- DATA_WIDTH, 32, datapath and address width; only 32 is supported.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- mem_read  in  1  MEM-stage instruction is a load
- mem_write  in  1  MEM-stage instruction is a store; never high together with mem_read
- funct3  in  3  load/store type
- addr  in  ADDR_WIDTH  effective byte address
- store_data  in  DATA_WIDTH  rs2 value
- stall  out  1  hold IF..MEM pipeline registers
- load_valid  out  1  one-cycle pulse; load result is valid
- load_word  out  DATA_WIDTH  raw cache word, to the extender's data_in
- load_addr  out  ADDR_WIDTH  byte address, to the extender's data_address
- load_type  out  3  funct3, to the extender's l_type
- misalign_exc  out  1  misaligned-access pulse
- dc_req_valid  out  1  cache request valid
- dc_req_ready  in  1  cache accepts the request
- dc_we  out  1  1 = write
- dc_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0
- dc_wdata  out  DATA_WIDTH  formatted store data
- dc_wstrb  out  4  byte enables; 0000 on reads
- dc_resp_valid  in  1  read data valid or write acknowledge
- dc_rdata  in  DATA_WIDTH  cache read word

Behaviour:
- Encodings:
  - Loads: lb 000, lh 001, lw 010, lbu 100, lhu 101.
  - Stores: sb 000, sh 001, sw 010.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - A valid op goes to REQ. In the same edge, latch dc_addr = {addr[31:2],2'b00}, dc_we, dc_wdata, dc_wstrb, load_addr and load_type.
  - A store with an unknown funct3 is a no-op: no request and no stall.
- REQ:
  - dc_req_valid = 1; request fields are held stable.
  - On dc_req_valid & dc_req_ready, go to RESP.
- RESP:
  - dc_resp_valid is honoured only from the cycle after acceptance.
  - On dc_resp_valid, go to DONE; for loads, latch load_word = dc_rdata.
- DONE:
  - load_valid = 1 for loads only; stall = 0; next state is IDLE.
  - The pipeline advances on this edge, so the op is never reissued.
- Stall: combinational. stall = (IDLE & valid op & not trapped) | REQ | RESP.
- Minimum latency: a cache that is ready in REQ and responds one cycle later gives 3 stall cycles. load_valid rises 3 cycles after the op appears.
- Store formatting:
  - sw: wdata = data, strb = 1111.
  - sh: wdata = {2{data[15:0]}}, strb = addr[1] ? 1100 : 0011.
  - sb: wdata = {4{data[7:0]}}, strb = 0001 << addr[1:0].
- Loads with an unknown funct3 still issue the read; the extender yields 0.
- Misaligned access: lw/sw with addr[1:0] != 0, or lh/lhu/sh with addr[0] = 1. Handling depends on the macro; see Optional Feature.
- Reset:
  - Values: state = IDLE; load_valid, misalign_exc, dc_req_valid, dc_we = 0; load_word, load_addr, dc_addr, dc_wdata = 0; load_type = 3'b000; dc_wstrb = 0000.
  - Reset mid-transaction abandons the op; a late dc_resp_valid arriving in IDLE is ignored.
- dc_resp_valid outside RESP is always ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN
- Defined:
  - A misaligned op seen in IDLE issues no cache request and does not stall.
  - misalign_exc pulses for 1 cycle; the state stays IDLE.
- Undefined:
  - misalign_exc is tied to 0.
  - Misaligned ops proceed with the low address bits dropped for the request. Byte/halfword lanes are chosen from addr[1:0] / addr[1], matching the extender.

Decomposition:
- Shared package mem_pkg holds:
  - the funct3 load/store localparams;
  - the state enum typedef mau_state_t {IDLE, REQ, RESP, DONE};
  - the WSTRB_W = 4 constant.
- One natural combinational sub-module, store_formatter: inputs funct3, addr[1:0], store_data; outputs wdata, wstrb.
- The FSM and registers stay in mem_access_unit.

Test Plan:
- lw at 0x100, ready at once, resp 1 cycle later with 0xDEADBEEF:
  - dc_addr = 0x100, wstrb = 0000, stall high 3 cycles;
  - load_valid pulses with load_word 0xDEADBEEF, load_type 010.
- sb 0xA5 at 0x203 → dc_addr 0x200, wdata 0xA5A5A5A5, wstrb 1000, dc_we = 1; no load_valid.
- sh 0x1234 at 0x302 with dc_req_ready held low 4 cycles → request fields stable throughout; stall lasts 4 + 2 cycles.
- lh at 0x101:
  - macro defined: misalign_exc pulses once, no dc_req_valid, stall 0;
  - macro undefined: request at 0x100 completes normally.
- rst_n low during RESP, then dc_resp_valid asserted after reset → state IDLE, no load_valid, all outputs at reset values.
- Back-to-back lbu 0x10 then sw 0x14 → two distinct requests, no duplicate issue, DONE → IDLE → REQ sequence verified.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and helpers for the MEM-stage load/store sequencer.
package mem_pkg;

  localparam int WSTRB_W = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } mau_state_t;

  // Word ops need both low bits clear, halfword ops only bit 0; lhu exists only as a load.
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] a_lo,
                                         input logic       is_store);
    logic m;
    m = 1'b0;
    case (f3)
      F3_LW:   m = (a_lo != 2'b00);
      F3_LH:   m = a_lo[0];
      F3_LHU:  m = !is_store && a_lo[0];
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_formatter.sv
// Store lane formatter: replicates store data across the word and builds byte strobes.
// Purely combinational; unknown store types produce zero strobes.
module store_formatter
  import mem_pkg::*;
(
  input  logic [2:0]         funct3_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [31:0]        store_data_i,
  output logic [31:0]        wdata_o,
  output logic [WSTRB_W-1:0] wstrb_o
);

  always_comb begin
    wdata_o = '0;
    wstrb_o = '0;
    case (funct3_i)
      F3_SW: begin
        wdata_o = store_data_i;
        wstrb_o = 4'b1111;
      end
      F3_SH: begin
        wdata_o = {2{store_data_i[15:0]}};
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      F3_SB: begin
        wdata_o = {4{store_data_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lo_i;
      end
      default: begin
        wdata_o = '0;
        wstrb_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: one word-aligned cache request per op, pipeline stalled until the reply.
// Optional macro MISALIGN_TRAP_EN: misaligned ops raise misalign_exc instead of issuing a request.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  stall,
  output logic                  load_valid,
  output logic [DATA_WIDTH-1:0] load_word,
  output logic [ADDR_WIDTH-1:0] load_addr,
  output logic [2:0]            load_type,
  output logic                  misalign_exc,
  output logic                  dc_req_valid,
  input  logic                  dc_req_ready,
  output logic                  dc_we,
  output logic [ADDR_WIDTH-1:0] dc_addr,
  output logic [DATA_WIDTH-1:0] dc_wdata,
  output logic [WSTRB_W-1:0]    dc_wstrb,
  input  logic                  dc_resp_valid,
  input  logic [DATA_WIDTH-1:0] dc_rdata
);

  mau_state_t state_q, state_d;

  logic                  load_valid_q;
  logic                  misalign_q;
  logic [DATA_WIDTH-1:0] load_word_q;
  logic [ADDR_WIDTH-1:0] load_addr_q;
  logic [2:0]            load_type_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] dc_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [WSTRB_W-1:0]    wstrb_q;

  logic [DATA_WIDTH-1:0] fmt_wdata;
  logic [WSTRB_W-1:0]    fmt_wstrb;
  logic                  store_known;
  logic                  op_vld;
  logic                  trap;
  logic                  go;
  logic                  resp_hit;

  store_formatter u_store_formatter (
    .funct3_i     (funct3),
    .addr_lo_i    (addr[1:0]),
    .store_data_i (store_data),
    .wdata_o      (fmt_wdata),
    .wstrb_o      (fmt_wstrb)
  );

  // Unknown store types are dropped outright; unknown loads still read and the extender zeroes them.
  assign store_known = mem_write && ((funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW));
  assign op_vld      = mem_read || store_known;

`ifdef MISALIGN_TRAP_EN
  assign trap = op_vld && is_misaligned(funct3, addr[1:0], mem_write);
`else
  assign trap = 1'b0;
`endif

  assign go       = (state_q == IDLE) && op_vld && !trap;
  assign resp_hit = (state_q == RESP) && dc_resp_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go)            state_d = REQ;
      REQ:     if (dc_req_ready)  state_d = RESP;
      RESP:    if (dc_resp_valid) state_d = DONE;
      DONE:                       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      load_word_q  <= '0;
      load_addr_q  <= '0;
      load_type_q  <= 3'b000;
      we_q         <= 1'b0;
      dc_addr_q    <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      // Pulse lands in DONE, the one cycle where the pipeline advances.
      load_valid_q <= resp_hit && !we_q;
      misalign_q   <= (state_q == IDLE) && trap;
      if (go) begin
        dc_addr_q   <= {addr[ADDR_WIDTH-1:2], 2'b00};
        we_q        <= mem_write;
        wdata_q     <= mem_write ? fmt_wdata : '0;
        wstrb_q     <= mem_write ? fmt_wstrb : '0;
        load_addr_q <= addr;
        load_type_q <= funct3;
      end
      if (resp_hit && !we_q) begin
        load_word_q <= dc_rdata;
      end
    end
  end

  assign stall        = go || (state_q == REQ) || (state_q == RESP);
  assign dc_req_valid = (state_q == REQ);
  assign dc_we        = we_q;
  assign dc_addr      = dc_addr_q;
  assign dc_wdata     = wdata_q;
  assign dc_wstrb     = wstrb_q;
  assign load_valid   = load_valid_q;
  assign load_word    = load_word_q;
  assign load_addr    = load_addr_q;
  assign load_type    = load_type_q;
  assign misalign_exc = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: per-scenario tasks drive ops and a cache model and compare inline.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, load_valid, misalign_exc;
  logic [31:0] load_word, load_addr;
  logic [2:0]  load_type;
  logic        dc_req_valid, dc_req_ready, dc_we, dc_resp_valid;
  logic [31:0] dc_addr, dc_wdata, dc_rdata;
  logic [3:0]  dc_wstrb;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .funct3        (funct3),
    .addr          (addr),
    .store_data    (store_data),
    .stall         (stall),
    .load_valid    (load_valid),
    .load_word     (load_word),
    .load_addr     (load_addr),
    .load_type     (load_type),
    .misalign_exc  (misalign_exc),
    .dc_req_valid  (dc_req_valid),
    .dc_req_ready  (dc_req_ready),
    .dc_we         (dc_we),
    .dc_addr       (dc_addr),
    .dc_wdata      (dc_wdata),
    .dc_wstrb      (dc_wstrb),
    .dc_resp_valid (dc_resp_valid),
    .dc_rdata      (dc_rdata)
  );

  always #5 clk = ~clk;

  // Op list for the driver and observations it collects.
  logic        op_rd [2];
  logic        op_wr [2];
  logic [2:0]  op_f3 [2];
  logic [31:0] op_a  [2];
  logic [31:0] op_sd [2];
  int          n_ops;
  int          ready_delay;
  logic [31:0] resp_data;

  int          stall_cnt, lv_cnt, lv_cycle, mx_cnt, acc_cnt, reqv_cnt, req_unstable;
  int          first_req_cycle [2];
  logic [31:0] acc_addr  [2];
  logic [31:0] acc_wdata [2];
  logic [3:0]  acc_wstrb [2];
  logic        acc_we    [2];
  logic [31:0] lv_word, lv_addr;
  logic [2:0]  lv_type;

  task automatic idle_inputs();
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    funct3        = 3'b000;
    addr          = 32'h0;
    store_data    = 32'h0;
    dc_req_ready  = 1'b0;
    dc_resp_valid = 1'b0;
    dc_rdata      = 32'h0BAD_0BAD;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drives ops in order (each held while stall is high) and models a cache that is ready
  // from cycle ready_delay onward and answers one cycle after acceptance.
  task automatic run_ops(input int cycles);
    int          idx;
    logic        resp_nxt, hv_prev, accepted;
    logic [31:0] ha, hw;
    logic [3:0]  hs;
    idx = 0; resp_nxt = 1'b0; hv_prev = 1'b0;
    ha = '0; hw = '0; hs = '0;
    stall_cnt = 0; lv_cnt = 0; lv_cycle = -1; mx_cnt = 0; acc_cnt = 0; reqv_cnt = 0;
    req_unstable = 0;
    lv_word = '0; lv_addr = '0; lv_type = '0;
    for (int k = 0; k < 2; k++) begin
      first_req_cycle[k] = -1;
      acc_addr[k] = '0; acc_wdata[k] = '0; acc_wstrb[k] = '0; acc_we[k] = 1'b0;
    end
    for (int cyc = 0; cyc < cycles; cyc++) begin
      if (idx < n_ops) begin
        mem_read   = op_rd[idx];
        mem_write  = op_wr[idx];
        funct3     = op_f3[idx];
        addr       = op_a[idx];
        store_data = op_sd[idx];
      end else begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      dc_req_ready  = (cyc >= ready_delay);
      dc_resp_valid = resp_nxt;
      dc_rdata      = resp_nxt ? resp_data : 32'h0BAD_0BAD;
      @(negedge clk);
      if (stall) stall_cnt++;
      if (misalign_exc) mx_cnt++;
      if (load_valid) begin
        lv_cnt++;
        if (lv_cycle < 0) lv_cycle = cyc;
        lv_word = load_word;
        lv_addr = load_addr;
        lv_type = load_type;
      end
      if (dc_req_valid) begin
        reqv_cnt++;
        if (hv_prev && (dc_addr !== ha || dc_wdata !== hw || dc_wstrb !== hs)) req_unstable++;
        if (!hv_prev && acc_cnt < 2) first_req_cycle[acc_cnt] = cyc;
        ha = dc_addr; hw = dc_wdata; hs = dc_wstrb;
      end
      accepted = dc_req_valid && dc_req_ready;
      if (accepted) begin
        if (acc_cnt < 2) begin
          acc_addr[acc_cnt]  = dc_addr;
          acc_wdata[acc_cnt] = dc_wdata;
          acc_wstrb[acc_cnt] = dc_wstrb;
          acc_we[acc_cnt]    = dc_we;
        end
        acc_cnt++;
      end
      hv_prev  = dc_req_valid && !accepted;
      resp_nxt = accepted;
      if (idx < n_ops && !stall) idx++;
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    tests_run++;
    if ({stall, load_valid, misalign_exc, dc_req_valid, dc_we} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 00000", {stall, load_valid, misalign_exc, dc_req_valid, dc_we});
    end
    tests_run++;
    if ({load_word, load_addr, dc_addr, dc_wdata} !== 128'h0 || load_type !== 3'b000 || dc_wstrb !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_data: got word=%h laddr=%h daddr=%h wdata=%h type=%b strb=%b want all zero",
               load_word, load_addr, dc_addr, dc_wdata, load_type, dc_wstrb);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lw();
    n_ops = 1; ready_delay = 0; resp_data = 32'hDEAD_BEEF;
    op_rd[0] = 1'b1; op_wr[0] = 1'b0; op_f3[0] = 3'b010; op_a[0] = 32'h100; op_sd[0] = 32'h0;
    run_ops(8);
    tests_run++;
    if (acc_cnt !== 1 || acc_addr[0] !== 32'h100 || acc_wstrb[0] !== 4'b0000 || acc_we[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL lw_req: got n=%0d addr=%h strb=%b we=%b want n=1 addr=00000100 strb=0000 we=0",
               acc_cnt, acc_addr[0], acc_wstrb[0], acc_we[0]);
    end
    tests_run++;
    if (stall_cnt !== 3) begin
      tests_failed++;
      $display("FAIL lw_stall: got %0d cycles want 3", stall_cnt);
    end
    tests_run++;
    if (lv_cnt !== 1 || lv_cycle !== 3) begin
      tests_failed++;
      $display("FAIL lw_valid: got pulses=%0d at cycle %0d want 1 at cycle 3", lv_cnt, lv_cycle);
    end
    tests_run++;
    if (lv_word !== 32'hDEAD_BEEF || lv_type !== 3'b010 || lv_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL lw_data: got word=%h type=%b addr=%h want deadbeef 010 00000100", lv_word, lv_type, lv_addr);
    end
  endtask

  task automatic test_sb();
    n_ops = 1; ready_delay = 0; resp_data = 32'h7777_7777;
    op_rd[0] = 1'b0; op_wr[0] = 1'b1; op_f3[0] = 3'b000; op_a[0] = 32'h203; op_sd[0] = 32'h1234_56A5;
    run_ops(8);
    tests_run++;
    if (acc_cnt !== 1 || acc_addr[0] !== 32'h200 || acc_wdata[0] !== 32'hA5A5_A5A5 ||
        acc_wstrb[0] !== 4'b1000 || acc_we[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL sb_req: got n=%0d addr=%h wdata=%h strb=%b we=%b want 1 00000200 a5a5a5a5 1000 1",
               acc_cnt, acc_addr[0], acc_wdata[0], acc_wstrb[0], acc_we[0]);
    end
    tests_run++;
    if (lv_cnt !== 0 || stall_cnt !== 3) begin
      tests_failed++;
      $display("FAIL sb_done: got load_valid pulses=%0d stall=%0d want 0 and 3", lv_cnt, stall_cnt);
    end
  endtask

  task automatic test_sh_backpressure();
    n_ops = 1; ready_delay = 4; resp_data = 32'h0;
    op_rd[0] = 1'b0; op_wr[0] = 1'b1; op_f3[0] = 3'b001; op_a[0] = 32'h302; op_sd[0] = 32'hABCD_1234;
    run_ops(10);
    tests_run++;
    if (acc_cnt !== 1 || acc_addr[0] !== 32'h300 || acc_wdata[0] !== 32'h1234_1234 || acc_wstrb[0] !== 4'b1100) begin
      tests_failed++;
      $display("FAIL sh_req: got n=%0d addr=%h wdata=%h strb=%b want 1 00000300 12341234 1100",
               acc_cnt, acc_addr[0], acc_wdata[0], acc_wstrb[0]);
    end
    tests_run++;
    if (req_unstable !== 0 || reqv_cnt !== 4) begin
      tests_failed++;
      $display("FAIL sh_hold: got unstable=%0d req_valid cycles=%0d want 0 and 4", req_unstable, reqv_cnt);
    end
    tests_run++;
    if (stall_cnt !== 6) begin
      tests_failed++;
      $display("FAIL sh_stall: got %0d cycles want 6", stall_cnt);
    end
  endtask

  task automatic test_misaligned_lh();
    n_ops = 1; ready_delay = 0; resp_data = 32'h8001_7FFE;
    op_rd[0] = 1'b1; op_wr[0] = 1'b0; op_f3[0] = 3'b001; op_a[0] = 32'h101; op_sd[0] = 32'h0;
    run_ops(8);
`ifdef MISALIGN_TRAP_EN
    tests_run++;
    if (mx_cnt !== 1 || reqv_cnt !== 0 || stall_cnt !== 0 || lv_cnt !== 0) begin
      tests_failed++;
      $display("FAIL lh_trap: got exc=%0d req=%0d stall=%0d lv=%0d want 1 0 0 0", mx_cnt, reqv_cnt, stall_cnt, lv_cnt);
    end
`else
    tests_run++;
    if (mx_cnt !== 0 || acc_cnt !== 1 || acc_addr[0] !== 32'h100 || stall_cnt !== 3) begin
      tests_failed++;
      $display("FAIL lh_misal_req: got exc=%0d n=%0d addr=%h stall=%0d want 0 1 00000100 3",
               mx_cnt, acc_cnt, acc_addr[0], stall_cnt);
    end
    tests_run++;
    if (lv_cnt !== 1 || lv_word !== 32'h8001_7FFE || lv_type !== 3'b001 || lv_addr !== 32'h101) begin
      tests_failed++;
      $display("FAIL lh_misal_load: got lv=%0d word=%h type=%b addr=%h want 1 80017ffe 001 00000101",
               lv_cnt, lv_word, lv_type, lv_addr);
    end
`endif
  endtask

  task automatic test_unknown_store();
    n_ops = 1; ready_delay = 0; resp_data = 32'h0;
    op_rd[0] = 1'b0; op_wr[0] = 1'b1; op_f3[0] = 3'b011; op_a[0] = 32'h40; op_sd[0] = 32'h1111_2222;
    run_ops(6);
    tests_run++;
    if (reqv_cnt !== 0 || stall_cnt !== 0 || lv_cnt !== 0 || mx_cnt !== 0) begin
      tests_failed++;
      $display("FAIL bad_store: got req=%0d stall=%0d lv=%0d exc=%0d want all 0", reqv_cnt, stall_cnt, lv_cnt, mx_cnt);
    end
  endtask

  task automatic test_reset_mid_resp();
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h48; dc_req_ready = 1'b1;
    @(posedge clk); #1;          // REQ, accepted this cycle
    @(posedge clk); #1;          // RESP
    mem_read = 1'b0;
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b1 || dc_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_resp_state: got stall=%b req=%b want 1 0", stall, dc_req_valid);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dc_resp_valid = 1'b1; dc_rdata = 32'h55AA_55AA;
    @(posedge clk); #1;
    dc_resp_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({stall, load_valid, misalign_exc, dc_req_valid, dc_we} !== 5'b0 || load_word !== 32'h0 ||
        dc_addr !== 32'h0 || load_addr !== 32'h0 || load_type !== 3'b000 || dc_wstrb !== 4'b0000 || dc_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL late_resp: got ctrl=%b word=%h daddr=%h laddr=%h type=%b strb=%b wdata=%h want all zero",
               {stall, load_valid, misalign_exc, dc_req_valid, dc_we}, load_word, dc_addr, load_addr,
               load_type, dc_wstrb, dc_wdata);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    n_ops = 2; ready_delay = 0; resp_data = 32'h1122_3380;
    op_rd[0] = 1'b1; op_wr[0] = 1'b0; op_f3[0] = 3'b100; op_a[0] = 32'h10; op_sd[0] = 32'h0;
    op_rd[1] = 1'b0; op_wr[1] = 1'b1; op_f3[1] = 3'b010; op_a[1] = 32'h14; op_sd[1] = 32'hCAFE_F00D;
    run_ops(12);
    tests_run++;
    if (acc_cnt !== 2 || acc_addr[0] !== 32'h10 || acc_we[0] !== 1'b0 || acc_wstrb[0] !== 4'b0000) begin
      tests_failed++;
      $display("FAIL b2b_first: got n=%0d addr=%h we=%b strb=%b want 2 00000010 0 0000",
               acc_cnt, acc_addr[0], acc_we[0], acc_wstrb[0]);
    end
    tests_run++;
    if (acc_addr[1] !== 32'h14 || acc_we[1] !== 1'b1 || acc_wdata[1] !== 32'hCAFE_F00D || acc_wstrb[1] !== 4'b1111) begin
      tests_failed++;
      $display("FAIL b2b_second: got addr=%h we=%b wdata=%h strb=%b want 00000014 1 cafef00d 1111",
               acc_addr[1], acc_we[1], acc_wdata[1], acc_wstrb[1]);
    end
    tests_run++;
    if (lv_cnt !== 1 || lv_cycle !== 3 || lv_type !== 3'b100 || lv_word !== 32'h1122_3380) begin
      tests_failed++;
      $display("FAIL b2b_load: got lv=%0d at %0d type=%b word=%h want 1 at 3 100 11223380",
               lv_cnt, lv_cycle, lv_type, lv_word);
    end
    tests_run++;
    if (first_req_cycle[0] !== 1 || first_req_cycle[1] !== 5 || stall_cnt !== 6) begin
      tests_failed++;
      $display("FAIL b2b_seq: got req cycles %0d,%0d stall=%0d want 1,5 stall=6",
               first_req_cycle[0], first_req_cycle[1], stall_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    n_ops = 0; ready_delay = 0; resp_data = '0;
    test_reset();
    test_lw();
    test_sb();
    test_sh_backpressure();
    test_misaligned_lh();
    test_unknown_store();
    test_reset_mid_resp();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
